// File: rtl/layer_output_serializer_if.sv
// Parallel neuron-result capture bus and serial replay stream between two FC layers.
// master drives the neuron outputs and observes the stream; slave is the serializer.
interface layer_output_serializer_if #(
  parameter int neuronCount = 30,
  parameter int dataWidth   = 16
);
  logic [neuronCount*dataWidth-1:0] neuronOutputs;
  logic [neuronCount-1:0]           neuronOutputsValid;
  logic [dataWidth-1:0]             serialOut;
  logic                             serialOutValid;
  logic                             busy;
  logic                             overrunError;
  logic                             syncError;
  logic [15:0]                      frameCount;

  modport master (
    output neuronOutputs, neuronOutputsValid,
    input  serialOut, serialOutValid, busy, overrunError, syncError, frameCount
  );

  modport slave (
    input  neuronOutputs, neuronOutputsValid,
    output serialOut, serialOutValid, busy, overrunError, syncError, frameCount
  );
endinterface

// File: rtl/layer_output_serializer.sv
// Captures all neuron outputs of a layer and replays them one word per cycle, word 0 first after 1 cycle.
// No backpressure: captures arriving mid-frame are dropped and flagged; a GAP cycle always separates frames.
module layer_output_serializer #(
  parameter int neuronCount = 30,
  parameter int dataWidth   = 16
) (
  input logic                     clk,
  input logic                     rst,
  layer_output_serializer_if.slave bus
);
  localparam int busWidth = neuronCount * dataWidth;
  localparam int cntWidth = (neuronCount > 1) ? $clog2(neuronCount) : 1;
  localparam logic [cntWidth-1:0] lastIdx = cntWidth'(neuronCount - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state;
  logic [busWidth-1:0] buffer;
  logic [cntWidth-1:0] counter;
  logic                overrunError;
  logic                syncError;
  logic [15:0]         frameCount;

  logic capture;
  logic partial;

  assign capture = &bus.neuronOutputsValid;
  assign partial = (|bus.neuronOutputsValid) & ~capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      buffer       <= '0;
      counter      <= '0;
      overrunError <= 1'b0;
      syncError    <= 1'b0;
      frameCount   <= 16'd0;
    end else begin
      if (partial) begin
        syncError <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (capture) begin
            buffer  <= bus.neuronOutputs;
            counter <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // The frame in flight is never disturbed; a new capture is only recorded as an overrun.
          if (capture) begin
            overrunError <= 1'b1;
          end
          buffer <= buffer >> dataWidth;
          if (counter == lastIdx) begin
            state      <= GAP;
            frameCount <= frameCount + 16'd1;
          end else begin
            counter <= counter + cntWidth'(1);
          end
        end
        GAP: begin
          if (capture) begin
            buffer  <= bus.neuronOutputs;
            counter <= '0;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stream outputs depend only on registered state so downstream sees no input-to-output path.
  assign bus.serialOutValid = (state == SHIFT);
  assign bus.serialOut      = (state == SHIFT) ? buffer[dataWidth-1:0] : '0;
  assign bus.busy           = (state == SHIFT) || (state == GAP);
  assign bus.overrunError   = overrunError;
  assign bus.syncError      = syncError;
  assign bus.frameCount     = frameCount;
endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench: a 4-neuron instance covers framing, overrun, sync and reset; a 1-neuron instance covers the minimum frame.
module tb_layer_output_serializer;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  layer_output_serializer_if #(.neuronCount(4), .dataWidth(16)) ifA ();
  layer_output_serializer_if #(.neuronCount(1), .dataWidth(16)) ifB ();

  layer_output_serializer #(.neuronCount(4), .dataWidth(16)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA.slave)
  );

  layer_output_serializer #(.neuronCount(1), .dataWidth(16)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called in the cycle carrying word 0; returns in the cycle carrying word 3.
  task automatic shiftFrame(input string tag, input logic [63:0] d);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk($sformatf("%s_w%0d", tag, i), 64'(ifA.serialOut), 64'(d[i*16 +: 16]));
      chk($sformatf("%s_v%0d", tag, i), 64'(ifA.serialOutValid), 64'd1);
    end
  endtask

  logic [63:0] d1, d2, d3, d4, d5, d6, d7, d8;

  initial begin
    passed = 0;
    total  = 0;
    d1 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    d2 = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
    d3 = {16'h8001, 16'h7FFF, 16'h0000, 16'hFFFF};
    d4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    d5 = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    d6 = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
    d7 = {16'h1004, 16'h1003, 16'h1002, 16'h1001};
    d8 = {16'h2004, 16'h2003, 16'h2002, 16'h2001};

    rst = 1'b1;
    ifA.neuronOutputs      = '0;
    ifA.neuronOutputsValid = '0;
    ifB.neuronOutputs      = '0;
    ifB.neuronOutputsValid = '0;
    tick();
    tick();
    chk("rst_valid", 64'(ifA.serialOutValid), 64'd0);
    chk("rst_out",   64'(ifA.serialOut),      64'd0);
    chk("rst_busy",  64'(ifA.busy),           64'd0);
    chk("rst_ovr",   64'(ifA.overrunError),   64'd0);
    chk("rst_sync",  64'(ifA.syncError),      64'd0);
    chk("rst_fc",    64'(ifA.frameCount),     64'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 64'(ifA.busy), 64'd0);

    // Single frame.
    ifA.neuronOutputs      = d1;
    ifA.neuronOutputsValid = 4'b1111;
    tick();
    ifA.neuronOutputsValid = 4'b0000;
    chk("f1_busy", 64'(ifA.busy), 64'd1);
    shiftFrame("f1", d1);
    tick();
    chk("f1_gap_v",  64'(ifA.serialOutValid), 64'd0);
    chk("f1_gap_o",  64'(ifA.serialOut),      64'd0);
    chk("f1_gap_b",  64'(ifA.busy),           64'd1);
    chk("f1_fc",     64'(ifA.frameCount),     64'd1);
    tick();
    chk("f1_idle_b", 64'(ifA.busy), 64'd0);

    // Back-to-back frames, second capture sampled in GAP.
    ifA.neuronOutputs      = d2;
    ifA.neuronOutputsValid = 4'b1111;
    tick();
    ifA.neuronOutputsValid = 4'b0000;
    shiftFrame("f2", d2);
    tick();
    chk("f2_gap_v", 64'(ifA.serialOutValid), 64'd0);
    chk("f2_fc",    64'(ifA.frameCount),     64'd2);
    ifA.neuronOutputs      = d3;
    ifA.neuronOutputsValid = 4'b1111;
    tick();
    ifA.neuronOutputsValid = 4'b0000;
    shiftFrame("f3", d3);
    tick();
    chk("f3_gap_v", 64'(ifA.serialOutValid), 64'd0);
    chk("f3_fc",    64'(ifA.frameCount),     64'd3);
    chk("f3_ovr",   64'(ifA.overrunError),   64'd0);
    tick();

    // Capture during the second SHIFT cycle is an overrun.
    ifA.neuronOutputs      = d4;
    ifA.neuronOutputsValid = 4'b1111;
    tick();
    ifA.neuronOutputsValid = 4'b0000;
    chk("ov_w0", 64'(ifA.serialOut), 64'h1111);
    tick();
    chk("ov_w1", 64'(ifA.serialOut), 64'h2222);
    ifA.neuronOutputs      = d5;
    ifA.neuronOutputsValid = 4'b1111;
    tick();
    ifA.neuronOutputsValid = 4'b0000;
    chk("ov_flag", 64'(ifA.overrunError),   64'd1);
    chk("ov_w2",   64'(ifA.serialOut),      64'h3333);
    tick();
    chk("ov_w3",   64'(ifA.serialOut),      64'h4444);
    tick();
    chk("ov_gap",  64'(ifA.serialOutValid), 64'd0);
    chk("ov_fc",   64'(ifA.frameCount),     64'd4);
    tick();
    chk("ov_idle_v", 64'(ifA.serialOutValid), 64'd0);
    chk("ov_idle_b", 64'(ifA.busy),           64'd0);
    chk("ov_fc2",    64'(ifA.frameCount),     64'd4);

    // Partial valid sets syncError and captures nothing.
    ifA.neuronOutputs      = d6;
    ifA.neuronOutputsValid = 4'b0101;
    tick();
    ifA.neuronOutputsValid = 4'b0000;
    chk("sy_flag", 64'(ifA.syncError),      64'd1);
    chk("sy_v",    64'(ifA.serialOutValid), 64'd0);
    chk("sy_b",    64'(ifA.busy),           64'd0);
    tick();
    chk("sy_v2",   64'(ifA.serialOutValid), 64'd0);
    ifA.neuronOutputsValid = 4'b1111;
    tick();
    ifA.neuronOutputsValid = 4'b0000;
    shiftFrame("sy", d6);
    chk("sy_keep", 64'(ifA.syncError), 64'd1);
    tick();
    chk("sy_fc", 64'(ifA.frameCount), 64'd5);
    tick();

    // Reset after word 1 aborts the frame; next capture restarts at word 0.
    ifA.neuronOutputs      = d7;
    ifA.neuronOutputsValid = 4'b1111;
    tick();
    ifA.neuronOutputsValid = 4'b0000;
    chk("ra_w0", 64'(ifA.serialOut), 64'h1001);
    tick();
    chk("ra_w1", 64'(ifA.serialOut), 64'h1002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ra_v",    64'(ifA.serialOutValid), 64'd0);
    chk("ra_o",    64'(ifA.serialOut),      64'd0);
    chk("ra_b",    64'(ifA.busy),           64'd0);
    chk("ra_fc",   64'(ifA.frameCount),     64'd0);
    chk("ra_ovr",  64'(ifA.overrunError),   64'd0);
    chk("ra_sync", 64'(ifA.syncError),      64'd0);
    tick();
    chk("ra_idle_v", 64'(ifA.serialOutValid), 64'd0);
    ifA.neuronOutputs      = d8;
    ifA.neuronOutputsValid = 4'b1111;
    tick();
    ifA.neuronOutputsValid = 4'b0000;
    shiftFrame("rb", d8);
    tick();
    chk("rb_fc", 64'(ifA.frameCount), 64'd1);
    tick();

    // Single-neuron instance: capture every second cycle.
    ifB.neuronOutputs      = 16'h1234;
    ifB.neuronOutputsValid = 1'b1;
    tick();
    ifB.neuronOutputsValid = 1'b0;
    chk("n1_w0", 64'(ifB.serialOut),      64'h1234);
    chk("n1_v0", 64'(ifB.serialOutValid), 64'd1);
    tick();
    chk("n1_g0", 64'(ifB.serialOutValid), 64'd0);
    chk("n1_f0", 64'(ifB.frameCount),     64'd1);
    ifB.neuronOutputs      = 16'hABCD;
    ifB.neuronOutputsValid = 1'b1;
    tick();
    ifB.neuronOutputsValid = 1'b0;
    chk("n1_w1", 64'(ifB.serialOut),      64'hABCD);
    chk("n1_v1", 64'(ifB.serialOutValid), 64'd1);
    tick();
    chk("n1_g1", 64'(ifB.serialOutValid), 64'd0);
    ifB.neuronOutputs      = 16'h8000;
    ifB.neuronOutputsValid = 1'b1;
    tick();
    ifB.neuronOutputsValid = 1'b0;
    chk("n1_w2", 64'(ifB.serialOut), 64'h8000);
    tick();
    chk("n1_fc",   64'(ifB.frameCount),   64'd3);
    chk("n1_ovr",  64'(ifB.overrunError), 64'd0);
    chk("n1_sync", 64'(ifB.syncError),    64'd0);
    tick();
    chk("n1_idle", 64'(ifB.busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
